// File: rtl/bcd_nonce_scheduler_pkg.sv
// Shared types for the BCD nonce scheduler.
// Digit helpers operate on 15-digit packed BCD, digit 0 in [3:0].
package bcd_pkg;

  localparam int BCD_DIGITS = 15;
  localparam int NONCE_W    = 60;

  typedef logic [NONCE_W-1:0] bcd_nonce_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  // One BCD digit add: returns {carry, digit}.
  function automatic logic [4:0] bcd_add_digit(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       cin
  );
    logic [4:0] s;
    logic [4:0] s10;
    s   = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    s10 = s - 5'd10;
    if (s > 5'd9) return {1'b1, s10[3:0]};
    else          return s;
  endfunction

  // True when every digit is 0..9.
  function automatic logic bcd_valid(input bcd_nonce_t v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_nonce_scheduler_if.sv
// Host command/config and core request/grant bundle.
// master drives config and requests; slave is the scheduler.
interface bcd_nonce_scheduler_if
  import bcd_pkg::*;
#(
  parameter int NUM_CORES = 4
);
  bcd_nonce_t           cfg_start_nonce;
  bcd_nonce_t           cfg_end_nonce;
  logic                 cmd_start;
  logic                 cmd_abort;
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_valid;
  bcd_nonce_t           grant_nonce;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [31:0]          issued_count;

  modport master (
    output cfg_start_nonce, cfg_end_nonce,
    output cmd_start, cmd_abort, req,
    input  grant, grant_valid, grant_nonce,
    input  busy, done, error, issued_count
  );

  modport slave (
    input  cfg_start_nonce, cfg_end_nonce,
    input  cmd_start, cmd_abort, req,
    output grant, grant_valid, grant_nonce,
    output busy, done, error, issued_count
  );
endinterface

// File: rtl/bcd_incr_comb.sv
// Combinational add of one BCD digit to a 15-digit BCD value.
// carry_out flags a wrap past 10^15-1.
module bcd_incr_comb
  import bcd_pkg::*;
(
  input  bcd_nonce_t value,
  input  logic [3:0] digit,
  output bcd_nonce_t sum,
  output logic       carry_out
);

  // Ripple the digit adder across all 15 digits.
  always_comb begin
    logic       c;
    logic [4:0] r;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r = bcd_add_digit(value[4*i +: 4], (i == 0) ? digit : 4'd0, c);
      sum[4*i +: 4] = r[3:0];
      c = r[4];
    end
    carry_out = c;
  end

endmodule

// File: rtl/bcd_nonce_scheduler.sv
// Round-robin nonce block scheduler over a BCD search range.
// One registered one-hot grant per cycle, carrying the current base.
module bcd_nonce_scheduler
  import bcd_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int BLOCK_STEP = 1
) (
  input logic                  clk,
  input logic                  rst,
  bcd_nonce_scheduler_if.slave bus
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t               state, state_n;
  bcd_nonce_t           cur, cur_n;
  logic                 wrapped, wrapped_n;
  logic [PW-1:0]        rr, rr_n;
  logic [NUM_CORES-1:0] grant, grant_n;
  bcd_nonce_t           nonce, nonce_n;
  logic                 done, done_n;
  logic                 error, error_n;
  logic [31:0]          cnt, cnt_n;

  bcd_nonce_t           cur_inc;
  logic                 cur_carry;

  logic [PW-1:0]        win;
  logic [PW-1:0]        win_nxt;
  logic                 cfg_ok;

  bcd_incr_comb u_incr (
    .value     (cur),
    .digit     (4'(BLOCK_STEP)),
    .sum       (cur_inc),
    .carry_out (cur_carry)
  );

  // Rotate requests to rr, pick the lowest set bit, rotate back.
  always_comb begin
    logic [2*NUM_CORES-1:0] dbl;
    logic [NUM_CORES-1:0]   rot;
    logic [PW-1:0]          off;
    int                     s;
    dbl = {bus.req, bus.req} >> rr;
    rot = dbl[NUM_CORES-1:0];
    off = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rot[i]) off = i[PW-1:0];
    end
    s = int'(off) + int'(rr);
    if (s >= NUM_CORES) s = s - NUM_CORES;
    win = s[PW-1:0];
    s = s + 1;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    win_nxt = s[PW-1:0];
  end

  assign cfg_ok = bcd_valid(bus.cfg_start_nonce)
               && bcd_valid(bus.cfg_end_nonce)
               && (bus.cfg_start_nonce <= bus.cfg_end_nonce);

  // Next-state and next-output decode for the whole scheduler.
  always_comb begin
    state_n   = state;
    cur_n     = cur;
    wrapped_n = wrapped;
    rr_n      = rr;
    grant_n   = '0;
    nonce_n   = nonce;
    done_n    = done;
    error_n   = error;
    cnt_n     = cnt;
    if (bus.cmd_abort) begin
      state_n = IDLE;
      done_n  = 1'b0;
      error_n = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.cmd_start) begin
            if (!cfg_ok) begin
              state_n = DONE;
              done_n  = 1'b0;
              error_n = 1'b1;
            end else begin
              state_n   = ISSUE;
              cur_n     = bus.cfg_start_nonce;
              wrapped_n = 1'b0;
              cnt_n     = '0;
              done_n    = 1'b0;
              error_n   = 1'b0;
            end
          end
        end
        ISSUE: begin
          if (|bus.req) begin
            if (wrapped || (cur > bus.cfg_end_nonce)) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              grant_n[win] = 1'b1;
              nonce_n      = cur;
              cur_n        = cur_inc;
              wrapped_n    = cur_carry;
              rr_n         = win_nxt;
              cnt_n        = (cnt == '1) ? cnt : cnt + 32'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur     <= '0;
      wrapped <= 1'b0;
      rr      <= '0;
      grant   <= '0;
      nonce   <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      wrapped <= wrapped_n;
      rr      <= rr_n;
      grant   <= grant_n;
      nonce   <= nonce_n;
      done    <= done_n;
      error   <= error_n;
      cnt     <= cnt_n;
    end
  end

  assign bus.grant        = grant;
  assign bus.grant_valid  = |grant;
  assign bus.grant_nonce  = nonce;
  assign bus.busy         = (state == ISSUE);
  assign bus.done         = done;
  assign bus.error        = error;
  assign bus.issued_count = cnt;

endmodule

// File: tb/tb_bcd_nonce_scheduler.sv
// Directed bench for bcd_nonce_scheduler.
// One task per scenario with inline checks.
module tb_bcd_nonce_scheduler;
  import bcd_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bcd_nonce_scheduler_if #(.NUM_CORES(4)) bus ();

  bcd_nonce_scheduler #(
    .NUM_CORES  (4),
    .BLOCK_STEP (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_start_nonce = '0;
    bus.cfg_end_nonce   = '0;
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    bus.req = '0;
    #12;
    checks++;
    if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_grant got %b/%b want 0000/0", bus.grant, bus.grant_valid);
    end
    checks++;
    if (bus.grant_nonce !== 60'h0 || bus.issued_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_nonce_cnt got %h/%0d want 0/0", bus.grant_nonce, bus.issued_count);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got %b%b%b want 000", bus.busy, bus.done, bus.error);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_range_end();
    bcd_nonce_t exp [5];
    exp = '{60'h95, 60'h96, 60'h97, 60'h98, 60'h99};
    bus.cfg_start_nonce = 60'h95;
    bus.cfg_end_nonce   = 60'h99;
    bus.req = 4'b0001;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_enter got busy=%b gv=%b want 1/0", bus.busy, bus.grant_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0001 || bus.grant_nonce !== exp[i]) begin
        errors++;
        $display("FAIL t1_grant%0d got %b/%h want 0001/%h", i, bus.grant, bus.grant_nonce, exp[i]);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_done got d=%b gv=%b b=%b want 1/0/0", bus.done, bus.grant_valid, bus.busy);
    end
    checks++;
    if (bus.issued_count !== 32'd5) begin
      errors++;
      $display("FAIL t1_count got %0d want 5", bus.issued_count);
    end
    bus.req = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.cfg_start_nonce = 60'h0;
    bus.cfg_end_nonce   = 60'h99;
    bus.req = 4'b1111;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.grant !== eg[i] || bus.grant_nonce !== 60'(i) || bus.grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL t2_rr%0d got %b/%h want %b/%h", i, bus.grant, bus.grant_nonce, eg[i], 60'(i));
      end
    end
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    bus.req = '0;
    checks++;
    if (bus.busy !== 1'b0 || bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL t2_abort got b=%b gv=%b want 0/0", bus.busy, bus.grant_valid);
    end
  endtask

  task automatic test_wrap();
    bus.cfg_start_nonce = 60'h999999999999998;
    bus.cfg_end_nonce   = 60'h999999999999999;
    bus.req = 4'b0001;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    tick();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_nonce !== 60'h999999999999998) begin
      errors++;
      $display("FAIL t3_g0 got %b/%h want 1/999999999999998", bus.grant_valid, bus.grant_nonce);
    end
    tick();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_nonce !== 60'h999999999999999) begin
      errors++;
      $display("FAIL t3_g1 got %b/%h want 1/999999999999999", bus.grant_valid, bus.grant_nonce);
    end
    tick();
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.done !== 1'b1 || bus.issued_count !== 32'd2) begin
      errors++;
      $display("FAIL t3_end got gv=%b d=%b n=%0d want 0/1/2", bus.grant_valid, bus.done, bus.issued_count);
    end
    tick();
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL t3_hold got gv=%b d=%b want 0/1", bus.grant_valid, bus.done);
    end
    bus.req = '0;
  endtask

  task automatic test_error();
    bus.cfg_start_nonce = 60'h00A;
    bus.cfg_end_nonce   = 60'h99;
    bus.req = 4'b0001;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    checks++;
    if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_digit got e=%b d=%b b=%b want 1/0/0", bus.error, bus.done, bus.busy);
    end
    tick();
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.error !== 1'b1) begin
      errors++;
      $display("FAIL t4_nogrant got gv=%b e=%b want 0/1", bus.grant_valid, bus.error);
    end
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL t4_clear got %b want 0", bus.error);
    end
    bus.cfg_start_nonce = 60'h50;
    bus.cfg_end_nonce   = 60'h40;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    checks++;
    if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_order got e=%b d=%b b=%b want 1/0/0", bus.error, bus.done, bus.busy);
    end
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    bus.req = '0;
  endtask

  task automatic test_abort();
    bus.cfg_start_nonce = 60'h10;
    bus.cfg_end_nonce   = 60'h99;
    bus.req = 4'b0001;
    bus.cmd_start = 1'b1;
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL t5_both got b=%b e=%b want 0/0", bus.busy, bus.error);
    end
    tick();
    checks++;
    if (bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_idle got gv=%b want 0", bus.grant_valid);
    end
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    tick();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_nonce !== 60'h10) begin
      errors++;
      $display("FAIL t5_run got %b/%h want 1/10", bus.grant_valid, bus.grant_nonce);
    end
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_abort got gv=%b b=%b want 0/0", bus.grant_valid, bus.busy);
    end
    bus.req = '0;
  endtask

  task automatic test_async_reset();
    bus.cfg_start_nonce = 60'h10;
    bus.cfg_end_nonce   = 60'h99;
    bus.req = 4'b0001;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_nonce !== 60'h11) begin
      errors++;
      $display("FAIL t6_pre got %b/%h want 1/11", bus.grant_valid, bus.grant_nonce);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.grant !== 4'b0 || bus.grant_nonce !== 60'h0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.error !== 1'b0 || bus.issued_count !== 32'd0) begin
      errors++;
      $display("FAIL t6_async got g=%b n=%h b=%b cnt=%0d want 0", bus.grant, bus.grant_nonce,
               bus.busy, bus.issued_count);
    end
    #1 rst = 1'b0;
    tick();
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.grant_nonce !== 60'h10 || bus.issued_count !== 32'd1) begin
      errors++;
      $display("FAIL t6_restart got %b/%h/%0d want 0001/10/1", bus.grant, bus.grant_nonce,
               bus.issued_count);
    end
    bus.req = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_range_end();
    test_round_robin();
    test_wrap();
    test_error();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
